// File: rtl/exp7_unidade_controle_pkg.sv
// Shared state codes for the memory-game control unit; db_estado decodes
// against these in the top level and the bench alike.
package exp7_unidade_controle_pkg;

  localparam logic [4:0] ST_INICIAL          = 5'h00;
  localparam logic [4:0] ST_PREPARACAO       = 5'h01;
  localparam logic [4:0] ST_REGISTRA_NIVEL   = 5'h02;
  localparam logic [4:0] ST_MOSTRA_JOGADA    = 5'h03;
  localparam logic [4:0] ST_APAGA_JOGADA     = 5'h04;
  localparam logic [4:0] ST_FIM_MOSTRA       = 5'h05;
  localparam logic [4:0] ST_PROXIMO_MOSTRA   = 5'h06;
  localparam logic [4:0] ST_ESPERA_JOGADA    = 5'h07;
  localparam logic [4:0] ST_REGISTRA_JOGADA  = 5'h08;
  localparam logic [4:0] ST_COMPARA          = 5'h09;
  localparam logic [4:0] ST_PROXIMA_JOGADA   = 5'h0A;
  localparam logic [4:0] ST_PROXIMA_RODADA   = 5'h0B;
  localparam logic [4:0] ST_ESPERA_ESCRITA   = 5'h0C;
  localparam logic [4:0] ST_REGISTRA_ESCRITA = 5'h0D;
  localparam logic [4:0] ST_GANHOU           = 5'h0E;
  localparam logic [4:0] ST_PERDEU           = 5'h0F;
  localparam logic [4:0] ST_TIMEOUT          = 5'h10;

  typedef enum logic [4:0] {
    INICIAL          = ST_INICIAL,
    PREPARACAO       = ST_PREPARACAO,
    REGISTRA_NIVEL   = ST_REGISTRA_NIVEL,
    MOSTRA_JOGADA    = ST_MOSTRA_JOGADA,
    APAGA_JOGADA     = ST_APAGA_JOGADA,
    FIM_MOSTRA       = ST_FIM_MOSTRA,
    PROXIMO_MOSTRA   = ST_PROXIMO_MOSTRA,
    ESPERA_JOGADA    = ST_ESPERA_JOGADA,
    REGISTRA_JOGADA  = ST_REGISTRA_JOGADA,
    COMPARA          = ST_COMPARA,
    PROXIMA_JOGADA   = ST_PROXIMA_JOGADA,
    PROXIMA_RODADA   = ST_PROXIMA_RODADA,
    ESPERA_ESCRITA   = ST_ESPERA_ESCRITA,
    REGISTRA_ESCRITA = ST_REGISTRA_ESCRITA,
    GANHOU           = ST_GANHOU,
    PERDEU           = ST_PERDEU,
    ESTADO_TIMEOUT   = ST_TIMEOUT
  } estado_t;

endpackage

// File: rtl/exp7_unidade_controle.sv
// Moore control FSM for the memory game: sequences the datapath strobes
// and drives the pronto/ganhou/perdeu/timeout status bits.
module exp7_unidade_controle
  import exp7_unidade_controle_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimC,
  input  logic       fimCR,
  input  logic       meioCR,
  input  logic       fimTM,
  input  logic       meioTM,
  input  logic       fimTempo,
  input  logic       meioTempo,
  input  logic       nivel_jogadas_reg,
  input  logic       nivel_tempo_reg,
  input  logic       modo2_reg,
  output logic       zeraR,
  output logic       registraR,
  output logic       registraN,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraCR,
  output logic       contaCR,
  output logic       zeraTM,
  output logic       contaTM,
  output logic       zeraTempo,
  output logic       contaTempo,
  output logic       gravaM,
  output logic       ativa_leds_mem,
  output logic       ativa_leds_jog,
  output logic       toca,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic [4:0] db_estado
);

  estado_t estado_q, estado_d;
  logic    limite, ultima;

  // fimC is part of the datapath contract but the sequence never needs it.
  logic unused_fimc;
  assign unused_fimc = fimC;

  assign limite = nivel_tempo_reg   ? meioTempo : fimTempo;
  assign ultima = nivel_jogadas_reg ? fimCR     : meioCR;

  always_ff @(posedge clock) begin
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:          if (iniciar) estado_d = PREPARACAO;
      PREPARACAO:       estado_d = REGISTRA_NIVEL;
      REGISTRA_NIVEL:   estado_d = modo2_reg ? ESPERA_ESCRITA : MOSTRA_JOGADA;
      MOSTRA_JOGADA:    if (meioTM) estado_d = APAGA_JOGADA;
      APAGA_JOGADA:     if (fimTM)
                          estado_d = enderecoIgualRodada ? FIM_MOSTRA : PROXIMO_MOSTRA;
      PROXIMO_MOSTRA:   estado_d = MOSTRA_JOGADA;
      FIM_MOSTRA:       estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA:    if (jogada_feita) estado_d = REGISTRA_JOGADA;
                        else if (limite)  estado_d = ESTADO_TIMEOUT;
      REGISTRA_JOGADA:  estado_d = COMPARA;
      COMPARA:          if (!jogada_correta)           estado_d = PERDEU;
                        else if (!enderecoIgualRodada) estado_d = PROXIMA_JOGADA;
                        else if (ultima)               estado_d = GANHOU;
                        else                           estado_d = PROXIMA_RODADA;
      PROXIMA_JOGADA:   estado_d = ESPERA_JOGADA;
      PROXIMA_RODADA:   estado_d = modo2_reg ? ESPERA_ESCRITA : MOSTRA_JOGADA;
      ESPERA_ESCRITA:   if (jogada_feita) estado_d = REGISTRA_ESCRITA;
                        else if (limite)  estado_d = ESTADO_TIMEOUT;
      REGISTRA_ESCRITA: estado_d = ESPERA_JOGADA;
      GANHOU, PERDEU, ESTADO_TIMEOUT:
                        if (iniciar) estado_d = PREPARACAO;
      default:          estado_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraR = 1'b0; registraR = 1'b0; registraN = 1'b0;
    zeraC = 1'b0; contaC = 1'b0; zeraCR = 1'b0; contaCR = 1'b0;
    zeraTM = 1'b0; contaTM = 1'b0; zeraTempo = 1'b0; contaTempo = 1'b0;
    gravaM = 1'b0; ativa_leds_mem = 1'b0; ativa_leds_jog = 1'b0; toca = 1'b0;
    pronto = 1'b0; ganhou = 1'b0; perdeu = 1'b0; timeout = 1'b0;
    case (estado_q)
      PREPARACAO:       begin zeraR = 1'b1; zeraC = 1'b1; zeraCR = 1'b1;
                              zeraTM = 1'b1; zeraTempo = 1'b1; end
      REGISTRA_NIVEL:   registraN = 1'b1;
      MOSTRA_JOGADA:    begin ativa_leds_mem = 1'b1; toca = 1'b1; contaTM = 1'b1; end
      APAGA_JOGADA:     contaTM = 1'b1;
      PROXIMO_MOSTRA:   begin contaC = 1'b1; zeraTM = 1'b1; end
      FIM_MOSTRA:       begin zeraC = 1'b1; zeraTM = 1'b1; zeraTempo = 1'b1; end
      ESPERA_JOGADA,
      ESPERA_ESCRITA:   begin contaTempo = 1'b1; ativa_leds_jog = 1'b1; end
      REGISTRA_JOGADA:  begin registraR = 1'b1; zeraTempo = 1'b1; end
      PROXIMA_JOGADA:   begin contaC = 1'b1; zeraTempo = 1'b1; end
      // Mode 2 keeps the address moving forward so the new play lands past the sequence.
      PROXIMA_RODADA:   begin contaCR = 1'b1; zeraTM = 1'b1; zeraTempo = 1'b1;
                              if (modo2_reg) contaC = 1'b1; else zeraC = 1'b1; end
      REGISTRA_ESCRITA: begin gravaM = 1'b1; registraR = 1'b1; zeraC = 1'b1;
                              zeraTempo = 1'b1; end
      GANHOU:           begin pronto = 1'b1; ganhou = 1'b1; end
      PERDEU:           begin pronto = 1'b1; perdeu = 1'b1; end
      ESTADO_TIMEOUT:   begin pronto = 1'b1; timeout = 1'b1; end
      default:          ;
    endcase
  end

  assign db_estado = estado_q;

endmodule
